// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port integer register file
//
// Sits between decode (read + reserve) and writeback (write). Provides:
//   * N_RD registered read ports (data and pending flag one cycle after enable)
//   * N_WR write ports (higher-numbered port wins on same-address conflict)
//   * a per-register pending scoreboard (set by reserve, cleared by write)
//   * a sequenced clear that zeroes one entry per cycle while oBusy is high
// Register 0 is hard-wired to zero and is never pending.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read that matches a same-cycle write returns the write data
//   undefined -> a same-cycle read returns the pre-write array contents
//
// Ports:
//   iClk      in   1            clock
//   iRst      in   1            asynchronous active-high reset
//   iRdEn     in   N_RD         per-port read enable
//   iRdAddr   in   N_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   oRdData   out  N_RD*DATA_W  registered read data
//   oRdPend   out  N_RD         registered pending flag of the register read
//   iWrEn     in   N_WR         per-port write enable
//   iWrAddr   in   N_WR*ADDR_W  write addresses
//   iWrData   in   N_WR*DATA_W  write data
//   iRsvEn    in   1            reserve request (mark register pending)
//   iRsvAddr  in   ADDR_W       register to reserve
//   iClr      in   1            pulse that starts the clear sequence
//   oBusy     out  1            high while the clear sequence runs
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int N_RD   = 2,
    parameter int N_WR   = 1
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [N_RD-1:0]          iRdEn,
    input  logic [N_RD*ADDR_W-1:0]   iRdAddr,
    output logic [N_RD*DATA_W-1:0]   oRdData,
    output logic [N_RD-1:0]          oRdPend,
    input  logic [N_WR-1:0]          iWrEn,
    input  logic [N_WR*ADDR_W-1:0]   iWrAddr,
    input  logic [N_WR*DATA_W-1:0]   iWrData,
    input  logic                     iRsvEn,
    input  logic [ADDR_W-1:0]        iRsvAddr,
    input  logic                     iClr,
    output logic                     oBusy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [ADDR_W-1:0]               r_cnt;
    logic [ADDR_W-1:0]               w_cnt_next;

    logic [DATA_W-1:0]               r_mem [DEPTH];
    logic [DEPTH-1:0]                r_pend;
    logic [DEPTH-1:0]                w_pend_next;

    logic [N_RD-1:0][ADDR_W-1:0]     w_rd_addr;
    logic [N_WR-1:0][ADDR_W-1:0]     w_wr_addr;
    logic [N_WR-1:0][DATA_W-1:0]     w_wr_data;
    logic [N_WR-1:0]                 w_wr_act;
    logic                            w_idle;

    assign w_rd_addr = iRdAddr;
    assign w_wr_addr = iWrAddr;
    assign w_wr_data = iWrData;
    assign w_idle    = (r_state == S_IDLE);
    assign oBusy     = (r_state == S_CLEAR);

    // A write port is effective only outside the clear sequence and when it
    // targets a real register (address 0 is hard-wired to zero).
    genvar gi;
    generate
        for (gi = 0; gi < N_WR; gi++) begin : g_wr_act
            assign w_wr_act[gi] = iWrEn[gi] && w_idle && (w_wr_addr[gi] != '0);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Clear FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                // Entry 0 is already zero, so the sweep starts at 1.
                if (iClr) begin
                    w_state_next = S_CLEAR;
                    w_cnt_next   = ADDR_W'(1);
                end
            end
            S_CLEAR: begin
                if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage array. Later write ports are applied last so they win a
    // same-address conflict.
    // -----------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int w = 0; w < N_WR; w++) begin
                if (w_wr_act[w]) begin
                    r_mem[w_wr_addr[w]] <= w_wr_data[w];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending scoreboard. Reserve is applied after the write clears so a
    // same-cycle reserve (new producer) leaves the bit set.
    // -----------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pend;
        if (w_idle) begin
            if (iClr) begin
                w_pend_next = '0;
            end else begin
                for (int w = 0; w < N_WR; w++) begin
                    if (w_wr_act[w]) begin
                        w_pend_next[w_wr_addr[w]] = 1'b0;
                    end
                end
                if (iRsvEn && (iRsvAddr != '0)) begin
                    w_pend_next[iRsvAddr] = 1'b1;
                end
            end
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. Pending is always the pre-edge scoreboard value; only the
    // data path may be bypassed.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < N_RD; gi++) begin : g_rd
            logic [DATA_W-1:0] w_val;
            logic [DATA_W-1:0] r_data;
            logic              r_pnd;

            always_comb begin
                w_val = (w_rd_addr[gi] == '0) ? '0 : r_mem[w_rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < N_WR; w++) begin
                    if (w_wr_act[w] && (w_wr_addr[w] == w_rd_addr[gi])) begin
                        w_val = w_wr_data[w];
                    end
                end
`endif
            end

            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    r_data <= '0;
                    r_pnd  <= 1'b0;
                end else if (iRdEn[gi]) begin
                    if (w_idle) begin
                        r_data <= w_val;
                        r_pnd  <= r_pend[w_rd_addr[gi]];
                    end else begin
                        r_data <= '0;
                        r_pnd  <= 1'b0;
                    end
                end
            end

            assign oRdData[gi*DATA_W +: DATA_W] = r_data;
            assign oRdPend[gi]                  = r_pnd;
        end
    endgenerate

endmodule
